// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, state encoding and helpers for the nibble ALU sequencer
//
// Contents:
//   OP_XFER..OP_NOT : 3-bit {S2,S1,S0} operation codes of the 4-bit ALU
//   state_t         : sequencer FSM states (IDLE, RUN, DONE)
//   is_arith(op)    : 1 for arithmetic ops (S2=0), which chain carry between nibbles
package alu_seq_pkg;

    localparam logic [2:0] OP_XFER = 3'b000;  // A + Cin
    localparam logic [2:0] OP_ADD  = 3'b001;  // A + B + Cin
    localparam logic [2:0] OP_SUBB = 3'b010;  // A + ~B + Cin
    localparam logic [2:0] OP_DEC  = 3'b011;  // A + 1111 + Cin
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;  // ~A

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - runs a wide ALU operation through a 4-bit ALU one nibble per cycle
//
// Executes 4*NIBBLES-bit operations on an external combinational 4-bit ALU,
// least significant nibble first, chaining the carry between nibbles.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_op, req_cin              {S2,S1,S0} op code and carry-in
//   req_a, req_b                 wide operands
//   rsp_valid/rsp_ready          response handshake
//   rsp_g, rsp_cout              wide result and final carry (0 for logic ops)
//   alu_s2/s1/s0, alu_cin        ALU select and carry-in for the current nibble
//   alu_a, alu_b                 current operand nibbles
//   alu_g, alu_cout              ALU result for the current nibble
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 2,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic         req_cin,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_g,
    output logic         rsp_cout,
    output logic         alu_s2,
    output logic         alu_s1,
    output logic         alu_s0,
    output logic         alu_cin,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    input  logic [3:0]   alu_g,
    input  logic         alu_cout
);

    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   result_q;
    logic           run;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)      state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST)  state_d = ST_DONE;
            ST_DONE: if (rsp_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Every ALU-facing output comes straight from registers so it is stable
    // for the whole cycle; outside RUN the ALU is parked at select 000, all zero.
    always_comb begin
        run       = (state_q == ST_RUN);
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_DONE);
        rsp_g     = rsp_valid ? result_q : '0;
        rsp_cout  = rsp_valid & carry_q;
        {alu_s2, alu_s1, alu_s0} = run ? op_q : 3'b000;
        alu_cin   = run & carry_q;
        alu_a     = run ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
        alu_b     = run ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        idx_q   <= '0;
                        // Logic ops never see a carry, regardless of req_cin.
                        carry_q <= is_arith(req_op) ? req_cin : 1'b0;
                    end
                end
                ST_RUN: begin
                    result_q[{idx_q, 2'b00} +: 4] <= alu_g;
                    carry_q <= is_arith(op_q) ? alu_cout : 1'b0;
                    // idx parks on the last nibble; it is cleared on the next accept.
                    if (idx_q != LAST) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
